// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_MA = 2'b10,
        FWD_WB = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_unit.sv
// fwd_unit: per-operand forwarding select and interlock request.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [REG_ADDR_W-1:0] ma_dest,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  ex_wr,
    input  logic                  ma_wr,
    input  logic                  wb_wr,
    input  logic                  ex_mem_rd,
    output fwd_sel_e              sel,
    output logic                  raw
);

    logic nz, hit_ex, hit_ma, hit_wb;

    assign nz     = src != REG_ADDR_W'(REG_ZERO);
    assign hit_ex = nz && ex_wr && ex_dest == src;
    assign hit_ma = nz && ma_wr && ma_dest == src;
    assign hit_wb = nz && wb_wr && wb_dest == src;

    // A load in EX has no data yet, so the EX path is skipped for it.
    assign sel = !FWD_EN              ? FWD_RF :
                 hit_ex && !ex_mem_rd ? FWD_EX :
                 hit_ma               ? FWD_MA :
                 hit_wb               ? FWD_WB : FWD_RF;

    assign raw = FWD_EN ? hit_ex && ex_mem_rd : hit_ex || hit_ma || hit_wb;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: pipeline enables, flushes and EX operand forwarding selects
// for the 5-stage core, with branch penalty and data-wait handling.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter bit FWD_EN         = 1'b1,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_instr_ready,
    input  logic                  i_data_ready,
    input  logic [REG_ADDR_W-1:0] i_id_reg_src1,
    input  logic [REG_ADDR_W-1:0] i_id_reg_src2,
    input  logic [REG_ADDR_W-1:0] i_ex_reg_dest,
    input  logic [REG_ADDR_W-1:0] i_ma_reg_dest,
    input  logic [REG_ADDR_W-1:0] i_wb_reg_dest,
    input  logic                  i_ex_reg_wr,
    input  logic                  i_ma_reg_wr,
    input  logic                  i_wb_reg_wr,
    input  logic                  i_ex_mem_rd,
    input  logic                  i_ex_branch_taken,
    output logic                  o_if_clk_en,
    output logic                  o_id_clk_en,
    output logic                  o_ex_clk_en,
    output logic                  o_ma_clk_en,
    output logic                  o_id_flush,
    output logic                  o_ex_flush,
    output logic [1:0]            o_fwd_src1,
    output logic [1:0]            o_fwd_src2,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);

    hz_state_e  state, state_nx;
    fwd_sel_e   sel1, sel2;
    logic       raw1, raw2, pend, pend_nx;
    logic [2:0] fcnt, fcnt_nx;
    logic       if_en, id_en, ex_en, ma_en, id_fl, ex_fl;

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd1 (
        .src(i_id_reg_src1), .ex_dest(i_ex_reg_dest), .ma_dest(i_ma_reg_dest),
        .wb_dest(i_wb_reg_dest), .ex_wr(i_ex_reg_wr), .ma_wr(i_ma_reg_wr),
        .wb_wr(i_wb_reg_wr), .ex_mem_rd(i_ex_mem_rd), .sel(sel1), .raw(raw1)
    );

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd2 (
        .src(i_id_reg_src2), .ex_dest(i_ex_reg_dest), .ma_dest(i_ma_reg_dest),
        .wb_dest(i_wb_reg_dest), .ex_wr(i_ex_reg_wr), .ma_wr(i_ma_reg_wr),
        .wb_wr(i_wb_reg_wr), .ex_mem_rd(i_ex_mem_rd), .sel(sel2), .raw(raw2)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= RUN;
            pend        <= 1'b0;
            fcnt        <= '0;
            o_stall_cnt <= '0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            fcnt  <= fcnt_nx;
            if (!if_en && !(&o_stall_cnt))
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        fcnt_nx  = fcnt;
        if_en    = 1'b1;
        id_en    = 1'b1;
        ex_en    = 1'b1;
        ma_en    = 1'b1;
        id_fl    = 1'b0;
        ex_fl    = 1'b0;
        if (!i_data_ready) begin
            {if_en, id_en, ex_en, ma_en} = 4'b0000;
            pend_nx  = pend || i_ex_branch_taken;
            state_nx = MEM_WAIT;
        end else if (i_ex_branch_taken || pend) begin
            id_fl    = 1'b1;
            ex_fl    = 1'b1;
            pend_nx  = 1'b0;
            fcnt_nx  = PEN_M1;
            state_nx = BRANCH_PENALTY > 1 ? FLUSH : RUN;
        // A flush frozen by a data wait resumes straight out of MEM_WAIT.
        end else if (state != RUN && fcnt != 3'd0) begin
            id_fl    = 1'b1;
            fcnt_nx  = fcnt - 3'd1;
            state_nx = fcnt == 3'd1 ? RUN : FLUSH;
        end else begin
            if_en    = i_instr_ready && !raw1 && !raw2;
            id_en    = if_en;
            ex_fl    = !if_en;
            state_nx = RUN;
        end
    end

    assign o_if_clk_en = !i_rst_n || if_en;
    assign o_id_clk_en = !i_rst_n || id_en;
    assign o_ex_clk_en = !i_rst_n || ex_en;
    assign o_ma_clk_en = !i_rst_n || ma_en;
    assign o_id_flush  = i_rst_n && id_fl;
    assign o_ex_flush  = i_rst_n && ex_fl;
    assign o_fwd_src1  = i_rst_n ? sel1 : FWD_RF;
    assign o_fwd_src2  = i_rst_n ? sel2 : FWD_RF;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: three builds (default, legacy interlock, penalty 1 with 2-bit counter)
// driven in lockstep and checked against a cycle-level reference model.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0, rst_n = 1'b0, ir = 1'b1, dr = 1'b1;
    logic [4:0] s1 = '0, s2 = '0, exd = '0, mad = '0, wbd = '0;
    logic       exw = 1'b0, maw = 1'b0, wbw = 1'b0, memrd = 1'b0, br = 1'b0;

    logic        ifen[3], iden[3], exen[3], maen[3], idf[3], exf[3];
    logic [1:0]  fw1[3], fw2[3];
    logic [31:0] cnt0;
    logic [7:0]  cnt1;
    logic [1:0]  cnt2;

    int          compared = 0, fails = 0;
    int          fe[3]   = '{1, 0, 1};
    int          pen[3]  = '{2, 3, 1};
    longint      cmax[3] = '{64'hFFFF_FFFF, 64'hFF, 64'h3};
    bit          m_pend[3], n_pend[3];
    int          m_left[3], n_left[3];
    longint      m_cnt[3], n_cnt[3];

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_ready(ir), .i_data_ready(dr),
        .i_id_reg_src1(s1), .i_id_reg_src2(s2), .i_ex_reg_dest(exd), .i_ma_reg_dest(mad),
        .i_wb_reg_dest(wbd), .i_ex_reg_wr(exw), .i_ma_reg_wr(maw), .i_wb_reg_wr(wbw),
        .i_ex_mem_rd(memrd), .i_ex_branch_taken(br),
        .o_if_clk_en(ifen[0]), .o_id_clk_en(iden[0]), .o_ex_clk_en(exen[0]), .o_ma_clk_en(maen[0]),
        .o_id_flush(idf[0]), .o_ex_flush(exf[0]), .o_fwd_src1(fw1[0]), .o_fwd_src2(fw2[0]),
        .o_stall_cnt(cnt0)
    );

    hazard_fwd_ctrl #(.FWD_EN(1'b0), .BRANCH_PENALTY(3), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_ready(ir), .i_data_ready(dr),
        .i_id_reg_src1(s1), .i_id_reg_src2(s2), .i_ex_reg_dest(exd), .i_ma_reg_dest(mad),
        .i_wb_reg_dest(wbd), .i_ex_reg_wr(exw), .i_ma_reg_wr(maw), .i_wb_reg_wr(wbw),
        .i_ex_mem_rd(memrd), .i_ex_branch_taken(br),
        .o_if_clk_en(ifen[1]), .o_id_clk_en(iden[1]), .o_ex_clk_en(exen[1]), .o_ma_clk_en(maen[1]),
        .o_id_flush(idf[1]), .o_ex_flush(exf[1]), .o_fwd_src1(fw1[1]), .o_fwd_src2(fw2[1]),
        .o_stall_cnt(cnt1)
    );

    hazard_fwd_ctrl #(.BRANCH_PENALTY(1), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_ready(ir), .i_data_ready(dr),
        .i_id_reg_src1(s1), .i_id_reg_src2(s2), .i_ex_reg_dest(exd), .i_ma_reg_dest(mad),
        .i_wb_reg_dest(wbd), .i_ex_reg_wr(exw), .i_ma_reg_wr(maw), .i_wb_reg_wr(wbw),
        .i_ex_mem_rd(memrd), .i_ex_branch_taken(br),
        .o_if_clk_en(ifen[2]), .o_id_clk_en(iden[2]), .o_ex_clk_en(exen[2]), .o_ma_clk_en(maen[2]),
        .o_id_flush(idf[2]), .o_ex_flush(exf[2]), .o_fwd_src1(fw1[2]), .o_fwd_src2(fw2[2]),
        .o_stall_cnt(cnt2)
    );

    function automatic bit hit(logic [4:0] s, logic [4:0] d, logic w);
        return w && s == d && s != 5'd0;
    endfunction

    function automatic logic [1:0] efwd(int k, logic [4:0] s);
        if (fe[k] == 0) return 2'b00;
        if (hit(s, exd, exw) && !memrd) return 2'b01;
        if (hit(s, mad, maw)) return 2'b10;
        if (hit(s, wbd, wbw)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit eraw(int k);
        bit ex_hit = hit(s1, exd, exw) || hit(s2, exd, exw);
        if (fe[k] != 0) return memrd && ex_hit;
        return ex_hit || hit(s1, mad, maw) || hit(s2, mad, maw)
                      || hit(s1, wbd, wbw) || hit(s2, wbd, wbw);
    endfunction

    function automatic longint obs_cnt(int k);
        return k == 0 ? longint'(cnt0) : k == 1 ? longint'(cnt1) : longint'(cnt2);
    endfunction

    task automatic check(int k);
        logic [3:0] en;
        logic [1:0] fl, f1, f2;
        logic [9:0] obs, exp;
        n_pend[k] = m_pend[k];
        n_left[k] = m_left[k];
        en = 4'b1111;
        fl = 2'b00;
        f1 = efwd(k, s1);
        f2 = efwd(k, s2);
        if (!rst_n) begin
            f1 = 2'b00;
            f2 = 2'b00;
            n_pend[k] = 1'b0;
            n_left[k] = 0;
        end else if (!dr) begin
            en = 4'b0000;
            n_pend[k] = m_pend[k] || br;
        end else if (br || m_pend[k]) begin
            fl = 2'b11;
            n_pend[k] = 1'b0;
            n_left[k] = pen[k] - 1;
        end else if (m_left[k] > 0) begin
            fl = 2'b10;
            n_left[k] = m_left[k] - 1;
        end else if (!ir || eraw(k)) begin
            en = 4'b0011;
            fl = 2'b01;
        end
        n_cnt[k] = !rst_n ? 0 : (!en[3] && m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
        obs = {ifen[k], iden[k], exen[k], maen[k], idf[k], exf[k], fw1[k], fw2[k]};
        exp = {en, fl, f1, f2};
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL ctl%0d: got en/fl/fwd=%b, want %b", k, obs, exp);
        end
        compared++;
        assert (obs_cnt(k) === m_cnt[k]) else begin
            fails++;
            $error("FAIL cnt%0d: got %0d, want %0d", k, obs_cnt(k), m_cnt[k]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) check(k);
        @(posedge clk);
        m_pend = n_pend;
        m_left = n_left;
        m_cnt  = n_cnt;
        #1;
    endtask

    task automatic idle();
        {s1, s2, exd, mad, wbd} = '0;
        {exw, maw, wbw, memrd, br} = '0;
        ir = 1'b1;
        dr = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 1'b0;
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end
        idle();
        step();
        step();
        rst_n = 1'b1;
        s1 = 5'd3; exd = 5'd3; exw = 1'b1;
        step();
        step();
        idle();
        s2 = 5'd5; exd = 5'd5; exw = 1'b1; memrd = 1'b1;
        step();
        s2 = 5'd0;
        step();
        idle();
        step();
        s1 = 5'd4; mad = 5'd4; maw = 1'b1;
        step();
        maw = 1'b0;
        step();
        idle();
        br = 1'b1;
        step();
        br = 1'b0;
        repeat (4) step();
        dr = 1'b0;
        step();
        br = 1'b1;
        step();
        br = 1'b0;
        step();
        dr = 1'b1;
        repeat (4) step();
        br = 1'b1;
        step();
        br = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        // Long stall to push the 2-bit counter into saturation.
        ir = 1'b0;
        repeat (6) step();
        ir = 1'b1;
        repeat (600) begin
            s1    = 5'($urandom_range(0, 3));
            s2    = 5'($urandom_range(0, 3));
            exd   = 5'($urandom_range(0, 3));
            mad   = 5'($urandom_range(0, 3));
            wbd   = 5'($urandom_range(0, 3));
            exw   = 1'($urandom % 2);
            maw   = 1'($urandom % 2);
            wbw   = 1'($urandom % 2);
            memrd = ($urandom % 3) == 0;
            br    = ($urandom % 8) == 0;
            ir    = ($urandom % 6) != 0;
            dr    = ($urandom % 6) != 0;
            rst_n = ($urandom % 60) != 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
